// File: rtl/enemy_sprite_anim_ram_if.sv
// Pixel-read / sprite-write / animation-control bundle for the enemy sprite store.
// Latency: n/a (signal bundle only).
// Backpressure: none; reads are fire-and-forget, results are qualified by dout_valid.
// Ports: master = pixel path / sprite loader side, slave = sprite store side.
interface enemy_sprite_anim_ram_if #(
   parameter int DATA_WIDTH = 12,
   parameter int SPR_W_BITS = 5,
   parameter int SPR_H_BITS = 5,
   parameter int FRAME_BITS = 2,
   parameter int TICK_BITS  = 4
);
   // animation control
   logic                             frame_tick;
   logic                             anim_en;
   logic [TICK_BITS-1:0]             anim_period;
   logic [FRAME_BITS-1:0]            last_frame;
   // pixel read request
   logic                             mirror_x;
   logic                             rd_en;
   logic [SPR_W_BITS-1:0]            x;
   logic [SPR_H_BITS-1:0]            y;
   // sprite write port
   logic                             we;
   logic [FRAME_BITS-1:0]            wr_frame;
   logic [SPR_W_BITS+SPR_H_BITS-1:0] wr_addr;
   logic [DATA_WIDTH-1:0]            din;
   // pixel result and sequencer state
   logic [DATA_WIDTH-1:0]            dout;
   logic                             dout_valid;
   logic                             transparent;
   logic [FRAME_BITS-1:0]            cur_frame;

   modport master (
      output frame_tick, anim_en, anim_period, last_frame,
      output mirror_x, rd_en, x, y,
      output we, wr_frame, wr_addr, din,
      input  dout, dout_valid, transparent, cur_frame
   );

   modport slave (
      input  frame_tick, anim_en, anim_period, last_frame,
      input  mirror_x, rd_en, x, y,
      input  we, wr_frame, wr_addr, din,
      output dout, dout_valid, transparent, cur_frame
   );
endinterface

// File: rtl/enemy_sprite_anim_ram.sv
// Multi-frame enemy sprite RAM with animation sequencer, x-mirroring and transparency flag.
// Latency: 2 cycles from rd_en to dout/dout_valid; writes land at the next clock edge.
// Backpressure: none; one read and one write may be accepted every cycle.
// Ports: clk, reset (async, active-high), bus (slave modport of enemy_sprite_anim_ram_if:
//        animation control, pixel read request, sprite write port, pixel result, cur_frame).
module enemy_sprite_anim_ram #(
   parameter int                    DATA_WIDTH = 12,
   parameter int                    SPR_W_BITS = 5,
   parameter int                    SPR_H_BITS = 5,
   parameter int                    FRAME_BITS = 2,
   parameter int                    TICK_BITS  = 4,
   parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 12'hF0F
) (
   input  logic                  clk,
   input  logic                  reset,
   enemy_sprite_anim_ram_if.slave bus
);

   localparam int ADDR_W = FRAME_BITS + SPR_H_BITS + SPR_W_BITS;
   localparam int DEPTH  = 1 << ADDR_W;

   // sprite storage, frames stored back to back: address = {frame, y, x}
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [ADDR_W-1:0]     r_addr_q;
   logic                  r_v1;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_dout_valid;
   logic                  r_transparent;
   logic [FRAME_BITS-1:0] r_cur_frame;
   logic [TICK_BITS-1:0]  r_tick_cnt;

   logic [SPR_W_BITS-1:0] w_x_eff;
   logic [DATA_WIDTH-1:0] w_rd_word;

   // Mirroring a power-of-two-wide sprite is just the bitwise complement of x.
   assign w_x_eff   = bus.mirror_x ? ~bus.x : bus.x;
   assign w_rd_word = r_mem[r_addr_q];

   // Write port. No reset so the array maps onto block RAM; contents survive reset.
   // The read below samples the array before this edge's write, giving read-first
   // behaviour when the write and the RAM read hit the same address.
   always_ff @(posedge clk) begin
      if (bus.we) begin
         r_mem[{bus.wr_frame, bus.wr_addr}] <= bus.din;
      end
   end

   // Read pipeline. cur_frame is captured into the address with the request, so a
   // frame advance while the read is in flight cannot change which frame it sees.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr_q      <= '0;
         r_v1          <= 1'b0;
         r_dout        <= '0;
         r_dout_valid  <= 1'b0;
         r_transparent <= 1'b0;
      end else begin
         r_addr_q      <= {r_cur_frame, bus.y, w_x_eff};
         r_v1          <= bus.rd_en;
         r_dout_valid  <= r_v1;
         r_transparent <= r_v1 && (w_rd_word == KEY_COLOR);
         // dout keeps the last returned pixel between reads
         if (r_v1) begin
            r_dout <= w_rd_word;
         end
      end
   end

   // Animation sequencer: counts enabled frame ticks, advances the frame once the
   // count reaches anim_period. The >= comparisons make a reduced anim_period or
   // last_frame take effect on the very next tick instead of waiting for a wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cur_frame <= '0;
         r_tick_cnt  <= '0;
      end else if (bus.frame_tick && bus.anim_en) begin
         if (r_tick_cnt >= bus.anim_period) begin
            r_tick_cnt <= '0;
            if (r_cur_frame >= bus.last_frame) begin
               r_cur_frame <= '0;
            end else begin
               r_cur_frame <= r_cur_frame + FRAME_BITS'(1);
            end
         end else begin
            r_tick_cnt <= r_tick_cnt + TICK_BITS'(1);
         end
      end
   end

   assign bus.dout        = r_dout;
   assign bus.dout_valid  = r_dout_valid;
   assign bus.transparent = r_transparent;
   assign bus.cur_frame   = r_cur_frame;

endmodule

// File: tb/tb_enemy_sprite_anim_ram.sv
// Self-checking bench for enemy_sprite_anim_ram: reference model + scoreboard queue,
// directed scenarios (reset, latency, mirror, animation, collision, hold) then random traffic.
module tb_enemy_sprite_anim_ram;

   localparam logic [11:0] KEY = 12'hF0F;

   logic clk;
   logic reset;

   enemy_sprite_anim_ram_if #(
      .DATA_WIDTH(12), .SPR_W_BITS(5), .SPR_H_BITS(5), .FRAME_BITS(2), .TICK_BITS(4)
   ) bus ();

   enemy_sprite_anim_ram #(
      .DATA_WIDTH(12), .SPR_W_BITS(5), .SPR_H_BITS(5), .FRAME_BITS(2), .TICK_BITS(4),
      .KEY_COLOR(KEY)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected DUT outputs for one clock cycle
   typedef struct {
      logic        v;
      logic [11:0] d;
      logic        t;
      logic [1:0]  f;
   } exp_t;

   exp_t q[$];

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [11:0] mem [4096];
   logic [1:0]  m_frame;
   logic [3:0]  m_tick;
   logic        m_pv;      // read request issued last cycle, RAM access this edge
   logic [11:0] m_pa;
   logic [11:0] m_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_frame = 2'd0;
      m_tick  = 4'd0;
      m_pv    = 1'b0;
      m_pa    = 12'd0;
      m_last  = 12'd0;
   endtask

   // One clock: advance the model on the edge using the inputs held across it,
   // push the outputs expected for this cycle, then release the stimulus slot.
   task automatic cycle();
      exp_t        e;
      logic [4:0]  xe;
      @(posedge clk);
      if (m_pv) begin
         e.v    = 1'b1;
         e.d    = mem[m_pa];
         e.t    = (mem[m_pa] == KEY);
         m_last = e.d;
      end else begin
         e.v = 1'b0;
         e.d = m_last;
         e.t = 1'b0;
      end
      xe   = bus.mirror_x ? (5'd31 - bus.x) : bus.x;
      m_pv = bus.rd_en;
      m_pa = {m_frame, bus.y, xe};
      if (bus.we) mem[{bus.wr_frame, bus.wr_addr}] = bus.din;
      if (bus.frame_tick && bus.anim_en) begin
         if (m_tick >= bus.anim_period) begin
            m_tick  = 4'd0;
            m_frame = (m_frame >= bus.last_frame) ? 2'd0 : m_frame + 2'd1;
         end else begin
            m_tick = m_tick + 4'd1;
         end
      end
      e.f = m_frame;
      q.push_back(e);
      #1;
   endtask

   // monitor: compares every cycle that has an expectation queued
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_dout_valid",  bus.dout_valid,  e.v);
            chk("sb_dout",        bus.dout,        e.d);
            chk("sb_transparent", bus.transparent, e.t);
            chk("sb_cur_frame",   bus.cur_frame,   e.f);
         end
      end
   end

   logic [1:0]  anim_seq [9];
   logic [11:0] old_val;

   initial begin
      anim_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};

      reset           = 1'b1;
      bus.frame_tick  = 1'b0;
      bus.anim_en     = 1'b0;
      bus.anim_period = 4'd0;
      bus.last_frame  = 2'd0;
      bus.mirror_x    = 1'b0;
      bus.rd_en       = 1'b0;
      bus.x           = 5'd0;
      bus.y           = 5'd0;
      bus.we          = 1'b0;
      bus.wr_frame    = 2'd0;
      bus.wr_addr     = 10'd0;
      bus.din         = 12'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout",        bus.dout,        12'd0);
      chk("rst_dout_valid",  bus.dout_valid,  1'b0);
      chk("rst_transparent", bus.transparent, 1'b0);
      chk("rst_cur_frame",   bus.cur_frame,   2'd0);
      reset = 1'b0;

      // load the whole RAM with known content, keyed pixels sprinkled in
      for (int i = 0; i < 4096; i++) begin
         bus.we       = 1'b1;
         bus.wr_frame = 2'(i >> 10);
         bus.wr_addr  = 10'(i);
         bus.din      = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
         cycle();
      end
      bus.wr_frame = 2'd0;
      bus.wr_addr  = {5'd3, 5'd5};
      bus.din      = 12'h123;
      cycle();
      bus.wr_addr  = {5'd0, 5'd31};
      bus.din      = KEY;
      cycle();
      bus.wr_addr  = {5'd7, 5'd9};
      bus.din      = 12'h555;
      cycle();
      bus.we = 1'b0;
      cycle();

      // latency: request at cycle 0, data only at cycle 2
      bus.rd_en = 1'b1;
      bus.x     = 5'd5;
      bus.y     = 5'd3;
      cycle();
      bus.rd_en = 1'b0;
      chk("lat_valid_c1", bus.dout_valid, 1'b0);
      cycle();
      chk("lat_valid_c2", bus.dout_valid, 1'b1);
      chk("lat_dout_c2",  bus.dout,       12'h123);
      cycle();
      chk("lat_valid_c3", bus.dout_valid, 1'b0);
      chk("lat_hold_c3",  bus.dout,       12'h123);

      // mirror: x=0 reads column 31, which holds the key colour
      bus.rd_en    = 1'b1;
      bus.mirror_x = 1'b1;
      bus.x        = 5'd0;
      bus.y        = 5'd0;
      cycle();
      bus.rd_en    = 1'b0;
      bus.mirror_x = 1'b0;
      cycle();
      chk("mir_dout",        bus.dout,        KEY);
      chk("mir_transparent", bus.transparent, 1'b1);
      cycle();

      // collision: RAM read and write of the same word on the same edge
      old_val   = mem[{2'd0, 5'd7, 5'd9}];
      bus.rd_en = 1'b1;
      bus.x     = 5'd9;
      bus.y     = 5'd7;
      cycle();
      bus.we       = 1'b1;
      bus.wr_frame = 2'd0;
      bus.wr_addr  = {5'd7, 5'd9};
      bus.din      = 12'hABC;
      cycle();
      chk("col_old", bus.dout, old_val);
      bus.we    = 1'b0;
      bus.rd_en = 1'b0;
      cycle();
      chk("col_new", bus.dout, 12'hABC);
      cycle();

      // animation: period 2, loop 0..2
      bus.anim_en     = 1'b1;
      bus.anim_period = 4'd2;
      bus.last_frame  = 2'd2;
      for (int k = 0; k < 9; k++) begin
         bus.frame_tick = 1'b1;
         cycle();
         bus.frame_tick = 1'b0;
         chk("anim_seq", bus.cur_frame, anim_seq[k]);
         cycle();
      end

      // hold: one tick counted, then 5 ignored ticks, then resume from held count
      bus.frame_tick = 1'b1;
      cycle();
      bus.anim_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("hold_frame", bus.cur_frame, 2'd0);
      end
      bus.anim_en = 1'b1;
      cycle();
      chk("resume_tick2", bus.cur_frame, 2'd0);
      cycle();
      chk("resume_adv", bus.cur_frame, 2'd1);
      bus.frame_tick = 1'b0;
      cycle();

      // reset in the middle of back-to-back reads (v1 and dout_valid both high)
      bus.rd_en = 1'b1;
      bus.x     = 5'd1;
      bus.y     = 5'd1;
      cycle();
      cycle();
      bus.rd_en = 1'b0;
      reset     = 1'b1;
      #1;
      chk("arst_dout",        bus.dout,        12'd0);
      chk("arst_dout_valid",  bus.dout_valid,  1'b0);
      chk("arst_transparent", bus.transparent, 1'b0);
      chk("arst_cur_frame",   bus.cur_frame,   2'd0);
      q.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cycle();

      // randomized traffic
      bus.anim_period = 4'd1;
      bus.last_frame  = 2'd3;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            bus.anim_period = 4'($urandom_range(0, 3));
            bus.last_frame  = 2'($urandom);
         end
         bus.frame_tick = ($urandom_range(0, 3) == 0);
         bus.anim_en    = ($urandom_range(0, 7) != 0);
         bus.rd_en      = 1'($urandom);
         bus.mirror_x   = 1'($urandom);
         bus.x          = 5'($urandom);
         bus.y          = 5'($urandom);
         bus.we         = ($urandom_range(0, 3) == 0);
         bus.din        = ($urandom_range(0, 5) == 0) ? KEY : 12'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            // aim the write at the word the in-flight read is about to fetch
            bus.wr_frame = m_pa[11:10];
            bus.wr_addr  = m_pa[9:0];
         end else begin
            bus.wr_frame = 2'($urandom);
            bus.wr_addr  = 10'($urandom);
         end
         cycle();
      end
      bus.rd_en      = 1'b0;
      bus.we         = 1'b0;
      bus.frame_tick = 1'b0;
      repeat (3) cycle();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
